// File: rtl/clock_divider_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : clock_divider_bank_if
// Brief    : Control/status bundle for clock_divider_bank. The align signal
//            exists only when CLKDIV_ALIGN_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface clock_divider_bank_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
);
  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH-1:0] div_load;
  logic [CNT_W-1:0]  div_value;
`ifdef CLKDIV_ALIGN_EN
  logic              align;
`endif
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] rise_tick;
  logic [NUM_CH-1:0] pend_valid;

`ifdef CLKDIV_ALIGN_EN
  modport master (output ch_en, div_load, div_value, align,
                  input  clk_out, rise_tick, pend_valid);
  modport slave  (input  ch_en, div_load, div_value, align,
                  output clk_out, rise_tick, pend_valid);
`else
  modport master (output ch_en, div_load, div_value,
                  input  clk_out, rise_tick, pend_valid);
  modport slave  (input  ch_en, div_load, div_value,
                  output clk_out, rise_tick, pend_valid);
`endif
endinterface
`default_nettype wire

// File: rtl/clock_divider_bank.sv
`default_nettype none
// ============================================================================
// Module   : clock_divider_bank
// Brief    : Multi-channel programmable 50%-duty clock divider with glitch-free
//            divisor change and gating. Optional macro: CLKDIV_ALIGN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module clock_divider_bank #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 8,
  parameter int RESET_HALF = 2
) (
  input  logic                clock,
  input  logic                reset,
  clock_divider_bank_if.slave bus
);

  logic [CNT_W-1:0]  w_load_val;
  logic [NUM_CH-1:0] w_clk_out;
  logic [NUM_CH-1:0] w_rise_tick;
  logic [NUM_CH-1:0] w_pend_valid;
  logic              w_align;

  // A zero half-period is meaningless; treat it as the fastest divisor.
  assign w_load_val = (bus.div_value == '0) ? CNT_W'(1) : bus.div_value;

`ifdef CLKDIV_ALIGN_EN
  assign w_align = bus.align;
`else
  assign w_align = 1'b0;
`endif

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] r_half;
      logic [CNT_W-1:0] r_pend_h;
      logic             r_clk;
      logic             r_rise;
      logic             r_pend_valid;
      logic             w_active;
      logic             w_idle;
      logic             w_toggle;
      logic             w_load;

      // A high phase always runs to completion, so gating only bites when low.
      assign w_active = bus.ch_en[i] | r_clk;
      assign w_idle   = ~w_active;
      assign w_toggle = w_active && (r_cnt == r_half - CNT_W'(1));
      assign w_load   = bus.div_load[i];

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_cnt        <= '0;
          r_half       <= CNT_W'(RESET_HALF);
          r_pend_h     <= '0;
          r_clk        <= 1'b0;
          r_rise       <= 1'b0;
          r_pend_valid <= 1'b0;
        end else begin
          r_rise <= 1'b0;
          if (w_align && bus.ch_en[i]) begin
            r_cnt <= '0;
            r_clk <= 1'b0;
            if (w_load) begin
              r_half       <= w_load_val;
              r_pend_valid <= 1'b0;
            end else if (r_pend_valid) begin
              r_half       <= r_pend_h;
              r_pend_valid <= 1'b0;
            end
          end else if (w_idle) begin
            r_cnt <= '0;
            if (r_pend_valid) begin
              r_half       <= w_load ? w_load_val : r_pend_h;
              r_pend_valid <= 1'b0;
            end else if (w_load) begin
              r_pend_h     <= w_load_val;
              r_pend_valid <= 1'b1;
            end
          end else begin
            if (w_toggle) begin
              r_cnt <= '0;
              r_clk <= ~r_clk;
              if (!r_clk) begin
                r_rise <= 1'b1;
              end else if (r_pend_valid) begin
                // Divisor only switches at the end of a high phase.
                r_half       <= r_pend_h;
                r_pend_valid <= 1'b0;
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_load) begin
              r_pend_h     <= w_load_val;
              r_pend_valid <= 1'b1;
            end
          end
        end
      end

      assign w_clk_out[i]    = r_clk;
      assign w_rise_tick[i]  = r_rise;
      assign w_pend_valid[i] = r_pend_valid;
    end
  endgenerate

  assign bus.clk_out    = w_clk_out;
  assign bus.rise_tick  = w_rise_tick;
  assign bus.pend_valid = w_pend_valid;

endmodule
`default_nettype wire

// File: doc/clock_divider_bank.md
Name: clock_divider_bank

Overview:
Multi-channel, runtime-programmable clock divider. Replaces the fixed divide-by-2 and divide-by-4 dividers that feed the dmem, processor and regfile clocks. Each channel produces a 50%-duty divided clock plus a one-cycle rising-edge strobe. Divisor changes and channel gating are glitch-free, so downstream memories and the regfile never see a runt pulse.

Parameters:
NUM_CH, 4, number of independent output channels
CNT_W, 8, width of the half-period divisor and counter
RESET_HALF, 2, half-period loaded into every channel on reset (2 gives divide-by-4)

Ports:
clock  in  1  master clock; all state changes on its rising edge
reset  in  1  asynchronous, active-high reset
ch_en  in  NUM_CH  per-channel run enable
div_load  in  NUM_CH  per-channel one-cycle strobe: capture div_value as the pending half-period
div_value  in  CNT_W  new half-period value, shared across channels
align  in  1  phase-align strobe; present only with CLKDIV_ALIGN_EN
clk_out  out  NUM_CH  divided clocks, registered
rise_tick  out  NUM_CH  high for exactly the first clock cycle of each clk_out high phase
pend_valid  out  NUM_CH  a loaded divisor is waiting to be applied

Behaviour:
- Reset (asynchronous):
  - clk_out=0, rise_tick=0, pend_valid=0.
  - Counters=0; active half-period H=RESET_HALF.
  - Reset may assert at any cycle; outputs go low immediately, with no wait for a period boundary.
- Per channel i, each rising edge while running:
  - If cnt==H-1: cnt<=0 and clk_out toggles (this is the "toggle" event).
  - Otherwise: cnt<=cnt+1.
  - Output period is 2*H clock cycles, duty exactly 50%.
  - H=1 matches a divide-by-2 clock; H=2 matches a divide-by-4 clock.
- First edge after enable: with cnt=0 and clk_out=0, ch_en rising gives the first clk_out rise H cycles later. Counter runs from the cycle ch_en is sampled high.
- rise_tick[i] is registered: set in the same edge where clk_out[i] goes 0->1, cleared the next cycle.
- Divisor load:
  - div_load[i] captures div_value into pend_h[i] and sets pend_valid[i].
  - div_value=0 is clamped to 1.
  - A new load while pend_valid is set overwrites pend_h; the last load wins.
  - The pending value applies only at a 1->0 toggle: at that edge H<=pend_h, cnt<=0, pend_valid<=0.
  - If the channel is idle (not running, clk_out=0), the pending value applies on the next edge.
  - Load in the same cycle as a 1->0 toggle: the old pending value (if any) applies, and the new one remains pending.
  - Load in the same cycle as an idle apply: the new value is applied directly.
  - H never changes during a high phase or mid-low phase.
- Gating:
  - ch_en[i] deasserted while clk_out=1: the channel keeps counting until the 1->0 toggle, then stops with cnt=0, clk_out=0.
  - ch_en[i] deasserted while clk_out=0: the channel stops immediately, cnt<=0.
  - Re-enable always starts a fresh low phase of H cycles.
- Channels sharing H that are enabled in the same cycle remain phase-locked indefinitely.
- Counter arithmetic is unsigned CNT_W bits; H ranges 1..2^CNT_W-1; no wrap is possible because cnt never exceeds H-1.

Optional Feature:
CLKDIV_ALIGN_EN
- Defined:
  - Adds the align input. An align pulse forces, on the next edge, cnt<=0 and clk_out<=0 on every enabled channel. Any pending divisor is applied at that edge and rise_tick is suppressed.
  - Channels then restart together and are mutually phase-aligned.
  - A truncated high phase is permitted and documented; software issues align only while consumers are held in reset.
- Undefined: no align port; behaviour as above without it.

Test Plan:
1. Reset, ch_en=4'b1111, defaults. All clk_out rise 2 cycles after enable, period 4, 50% duty. rise_tick pulses once per period, coincident with the first high cycle.
2. Ch0 load div_value=1, ch1 load 2 while both are idle. Ch0 period 2, ch1 period 4; after 100 cycles, edge counts are exactly 50 and 25.
3. Ch0 running H=2; load div_value=5 during the high phase. Period stays 4 until the next fall, then becomes 10; pend_valid drops on that fall edge; no high or low phase shorter than 2 cycles.
4. Load div_value=0. Channel runs with H=1 (period 2).
5. Deassert ch_en during the second cycle of a high phase with H=3. clk_out stays high one more cycle, falls, then holds 0. Re-enable: rises after 3 cycles.
6. Reset asserted mid-high with H=4 and a pending load. clk_out, rise_tick and pend_valid go 0 asynchronously. After release H=RESET_HALF and the pending value is discarded. With CLKDIV_ALIGN_EN, align on staggered channels leads to identical edges afterwards.
